instr_realigner: RTL and testbench
==================================

INSTR_REALIGNER -- requirements
Module: instr_realigner

Interface
REQ-001 Parameter: CHERIoTEn, 1'b1, CHERIoT build enable; passed through only, no functional effect in this block.
REQ-002 Port: clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 Port: fetch_valid_i  input  1  fetch word valid.
REQ-005 Port: fetch_rdata_i  input  32  fetch word; word-aligned, sequential from the last redirect.
REQ-006 Port: fetch_err_i  input  1  bus error on this word.
REQ-007 Port: fetch_ready_o  output  1  realigner accepts a word this cycle.
REQ-008 Port: redirect_i  input  1  flush and restart.
REQ-009 Port: redirect_pc_i  input  32  new PC; bit 0 ignored.
REQ-010 Port: instr_valid_o  output  1  instr_o holds a complete instruction.
REQ-011 Port: instr_ready_i  input  1  downstream (compressed decoder stage) consumes instr_o.
REQ-012 Port: instr_o  output  ir_reg_t  aligned instruction: insn, pc, is_comp, errs.fetch_err; all other fields zero.

Function
REQ-013 Storage SHALL be a 4-entry halfword queue; each entry holds a 16-bit halfword and an error flag.
REQ-014 fetch_ready_o SHALL be 1 iff the queue count is <= 2 and redirect_i is 0; it SHALL NOT depend on instr_ready_i.
REQ-015 On fetch_valid_i & fetch_ready_o, rdata[15:0] then rdata[31:16] SHALL be enqueued, both carrying fetch_err_i.
REQ-016 When skip_lo is set, an accepted word SHALL enqueue only rdata[31:16], and skip_lo SHALL clear.
REQ-017 Head halfword [1:0] != 2'b11 SHALL be treated as compressed (1 halfword); otherwise the instruction is 32-bit (2 halfwords).
REQ-018 instr_valid_o SHALL be 1 iff count >= the head instruction length, or the head flag is set and count >= 1.
REQ-019 For a compressed instruction, insn SHALL be {16'b0, head}; for a 32-bit instruction, insn SHALL be {head+1, head}.
REQ-020 is_comp SHALL flag a compressed instruction.
REQ-021 errs.fetch_err SHALL be the OR of the flags of the halfwords used.
REQ-022 If the head flag is set, the instruction SHALL be emitted and consume 1 halfword, with insn 0.
REQ-023 Consumption SHALL occur on instr_valid_o & instr_ready_i.
REQ-024 On consumption, pc SHALL advance by 2 (compressed or error) or 4, modulo 2^32.
REQ-025 While instr_valid_o=1 and instr_ready_i=0, instr_o SHALL be held stable.
REQ-026 Enqueue and dequeue in the same cycle SHALL both take effect; count_next = count + enq - deq and SHALL never exceed 4.
REQ-027 A 32-bit instruction split across words SHALL wait, with valid=0, until the upper halfword arrives.
REQ-028 On redirect_i, the next-cycle queue SHALL be empty and pc SHALL equal {redirect_pc_i[31:1],1'b0}.
REQ-029 On redirect_i, skip_lo SHALL be set to redirect_pc_i[1].
REQ-030 On redirect_i, any same-cycle fetch word SHALL be dropped and any same-cycle consumption ignored.
REQ-031 instr_valid_o SHALL be 0 in the cycle after a redirect.
REQ-032 Latency: a word accepted in cycle N that completes the head instruction SHALL give instr_valid_o=1 in cycle N+1.

Reset
REQ-033 On rst_ni low: count=0, pc=0, skip_lo=0, instr_valid_o=0, fetch_ready_o=1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered halfwords immediately.

Structure
REQ-035 ir_reg_t, including the pc, is_comp and errs.fetch_err fields, SHALL live in super_pkg.
REQ-036 The queue depth constant SHALL live in super_pkg.
REQ-037 The design SHALL be a single module; the halfword queue SHALL be inline with no sub-module.

Verification
REQ-038 Reset, redirect to 0x100, words 0x00A30113 and 0x00000513 -> 32-bit insn 0x00A30113 at pc 0x100, then insn 0x00000513 at pc 0x104.
REQ-039 Redirect to 0x202, word 0x4501_1234 -> single instr: insn 0x00004501, is_comp=1, pc 0x202; low half discarded.
REQ-040 Words 0x01134505 and 0xABCD0051 -> C insn 0x4505 at pc 0, then 32-bit insn 0x00510113 at pc 2, not valid until the second word arrives.
REQ-041 Hold instr_ready_i=0 for 5 cycles with fetch_valid_i=1 -> instr_o stable, fetch_ready_o drops at count 3, count never exceeds 4.
REQ-042 Word with fetch_err_i=1 -> errs.fetch_err=1, insn 0, pc advances by 2; redirect in the same cycle as fetch_valid_i -> word dropped, valid 0 in the next cycle.

Source files
------------

// File: rtl/super_pkg.sv
// Shared types and constants for the instruction front end.
//   ir_reg_t     : instruction record handed to the decode stage
//   ir_errs_t    : per-instruction error flags carried with ir_reg_t
//   hw_entry_t   : one slot of the halfword realignment queue
//   HwQueueDepth : number of halfword slots in the realigner queue
package super_pkg;

  localparam int unsigned HwQueueDepth = 4;
  localparam int unsigned HwQueueIdxW  = $clog2(HwQueueDepth);
  // One extra bit so a full queue (count == depth) is representable.
  localparam int unsigned HwQueueCntW  = HwQueueIdxW + 1;

  typedef struct packed {
    logic fetch_err;
    logic illegal_insn;
  } ir_errs_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        is_comp;
    ir_errs_t    errs;
  } ir_reg_t;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } hw_entry_t;

  // RV compressed encodings are every halfword whose low two bits are not 2'b11.
  function automatic logic is_compressed(logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_realigner.sv
// Instruction realigner: turns a stream of word-aligned fetch words into whole
// RV32 instructions (16- or 32-bit) that may straddle word boundaries.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   fetch_valid_i          : fetch_rdata_i/fetch_err_i carry a word
//   fetch_rdata_i          : sequential word-aligned instruction word
//   fetch_err_i            : bus error attached to that word
//   fetch_ready_o          : a word is accepted this cycle when valid
//   redirect_i             : flush the queue and restart at redirect_pc_i
//   redirect_pc_i          : restart PC (bit 0 ignored)
//   instr_valid_o          : instr_o holds a complete instruction
//   instr_ready_i          : downstream consumes instr_o
//   instr_o                : aligned instruction record
module instr_realigner
  import super_pkg::*;
#(
  parameter bit CHERIoTEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output ir_reg_t     instr_o
);

  // Circular halfword queue: hd_q points at the oldest slot, cnt_q slots used.
  hw_entry_t [HwQueueDepth-1:0] q_q, q_d;
  logic [HwQueueIdxW-1:0]       hd_q, hd_d;
  logic [HwQueueCntW-1:0]       cnt_q, cnt_d;
  logic [31:0]                  pc_q, pc_d;
  // Set after a redirect to an odd halfword: drop the low half of the next word.
  logic                         skip_q, skip_d;

  logic [HwQueueIdxW-1:0] hd1_idx;
  logic [HwQueueIdxW-1:0] wr0_idx;
  logic [HwQueueIdxW-1:0] wr1_idx;
  hw_entry_t              head0;
  hw_entry_t              head1;
  logic                   head_comp;
  logic                   head_len1;
  logic                   fetch_acc;
  logic                   deq;
  logic [HwQueueCntW-1:0] enq_n;
  logic [HwQueueCntW-1:0] deq_n;

  // CHERIoTEn has no effect here; redirect_pc_i[0] is ignored by definition.
  logic unused_inputs;
  assign unused_inputs = ^{CHERIoTEn, redirect_pc_i[0]};

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  always_comb begin
    hd1_idx   = hd_q + 1'b1;
    head0     = q_q[hd_q];
    head1     = q_q[hd1_idx];
    head_comp = is_compressed(head0.hw);
    // Errored halfwords are emitted on their own, so they behave like 16-bit.
    head_len1 = head0.err | head_comp;
  end

  assign instr_valid_o = (cnt_q != '0) &
                         (head_len1 | (cnt_q >= HwQueueCntW'(2)));

  // Only take a word when both halves are guaranteed to fit.
  assign fetch_ready_o = (cnt_q <= HwQueueCntW'(HwQueueDepth - 2)) & ~redirect_i;
  assign fetch_acc     = fetch_valid_i & fetch_ready_o;
  assign deq           = instr_valid_o & instr_ready_i & ~redirect_i;

  // ---------------------------------------------------------------------------
  // Output record
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_o    = '0;
    instr_o.pc = pc_q;
    if (head0.err) begin
      instr_o.errs.fetch_err = 1'b1;
    end else if (head_comp) begin
      instr_o.insn    = {16'h0000, head0.hw};
      instr_o.is_comp = 1'b1;
    end else begin
      instr_o.insn           = {head1.hw, head0.hw};
      instr_o.errs.fetch_err = head1.err;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d     = q_q;
    hd_d    = hd_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    skip_d  = skip_q;
    enq_n   = '0;
    deq_n   = '0;
    // Writes are placed relative to the current head; a same-cycle dequeue
    // only moves hd_q, so these slots stay correct.
    wr0_idx = hd_q + cnt_q[HwQueueIdxW-1:0];
    wr1_idx = wr0_idx + 1'b1;

    if (fetch_acc) begin
      if (skip_q) begin
        q_d[wr0_idx].hw  = fetch_rdata_i[31:16];
        q_d[wr0_idx].err = fetch_err_i;
        enq_n            = HwQueueCntW'(1);
        skip_d           = 1'b0;
      end else begin
        q_d[wr0_idx].hw  = fetch_rdata_i[15:0];
        q_d[wr0_idx].err = fetch_err_i;
        q_d[wr1_idx].hw  = fetch_rdata_i[31:16];
        q_d[wr1_idx].err = fetch_err_i;
        enq_n            = HwQueueCntW'(2);
      end
    end

    if (deq) begin
      if (head_len1) begin
        deq_n = HwQueueCntW'(1);
        pc_d  = pc_q + 32'd2;
      end else begin
        deq_n = HwQueueCntW'(2);
        pc_d  = pc_q + 32'd4;
      end
      hd_d = hd_q + deq_n[HwQueueIdxW-1:0];
    end

    cnt_d = cnt_q + enq_n - deq_n;

    // Redirect overrides everything that happened this cycle.
    if (redirect_i) begin
      cnt_d  = '0;
      hd_d   = '0;
      pc_d   = {redirect_pc_i[31:1], 1'b0};
      skip_d = redirect_pc_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      hd_q   <= '0;
      cnt_q  <= '0;
      pc_q   <= '0;
      skip_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      hd_q   <= hd_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

endmodule

// File: tb/tb_instr_realigner.sv
// Self-checking bench for instr_realigner. Expected instructions are queued as
// stimulus is driven; a negedge monitor pops and compares on every consumption.
module tb_instr_realigner;
  import super_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  ir_reg_t     instr_o;

  always #5 clk = ~clk;

  instr_realigner #(.CHERIoTEn(1'b1)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fetch_valid_i (fetch_valid_i),
    .fetch_rdata_i (fetch_rdata_i),
    .fetch_err_i   (fetch_err_i),
    .fetch_ready_o (fetch_ready_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Scoreboard monitor: a consumption happens at the next posedge.
  always @(negedge clk) begin
    if (rst_ni && instr_valid_o && instr_ready_i && !redirect_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got insn %h pc %h, required no instruction",
                 instr_o.insn, instr_o.pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (instr_o.insn !== mon_e.insn || instr_o.pc !== mon_e.pc ||
            instr_o.errs.fetch_err !== mon_e.err || instr_o.errs.illegal_insn !== 1'b0 ||
            (!mon_e.err && instr_o.is_comp !== mon_e.comp)) begin
          errors++;
          $display("FAIL instr_out: got insn %h pc %h comp %b err %b, required insn %h pc %h comp %b err %b",
                   instr_o.insn, instr_o.pc, instr_o.is_comp, instr_o.errs.fetch_err,
                   mon_e.insn, mon_e.pc, mon_e.comp, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] insn, input logic [31:0] pc, input logic comp,
                      input logic err);
    exp_t e;
    e.insn = insn;
    e.pc   = pc;
    e.comp = comp;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
  endtask

  // Present a word until it is accepted (bounded); returns one cycle after acceptance.
  task automatic send_word(input logic [31:0] w, input logic e);
    logic acc;
    acc           = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = w;
    fetch_err_i   = e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = fetch_ready_o;
      tick();
      if (acc) break;
    end
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance within 20 cycles", w);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = '0;
    fetch_err_i   = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || instr_o.pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got valid %b ready %b pc %h, required 0 1 00000000",
               instr_valid_o, fetch_ready_o, instr_o.pc);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_redirect_32();
    instr_ready_i = 1'b1;
    push(32'h00A30113, 32'h100, 1'b0, 1'b0);
    push(32'h00000513, 32'h104, 1'b0, 1'b0);
    do_redirect(32'h100);
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o.pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_state: got valid %b pc %h, required 0 00000100",
               instr_valid_o, instr_o.pc);
    end
    send_word(32'h00A30113, 1'b0);
    checks++;
    if (instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_32: got valid %b, required 1", instr_valid_o);
    end
    send_word(32'h00000513, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL redirect_32_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_skip_lo();
    instr_ready_i = 1'b1;
    push(32'h00004501, 32'h202, 1'b1, 1'b0);
    do_redirect(32'h202);
    send_word(32'h45011234, 1'b0);
    drain();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0 || instr_valid_o !== 1'b0 || instr_o.pc !== 32'h204) begin
      errors++;
      $display("FAIL skip_lo: got pending %0d valid %b pc %h, required 0 0 00000204",
               exp_q.size(), instr_valid_o, instr_o.pc);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready_i = 1'b0;
    do_redirect(32'h500);
    send_word(32'h45054505, 1'b0);
    checks++;
    if (instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got valid %b, required 1", instr_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o.pc !== 32'h0 || fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid %b pc %h ready %b, required 0 00000000 1",
               instr_valid_o, instr_o.pc, fetch_ready_o);
    end
    tick();
    rst_ni        = 1'b1;
    instr_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_split();
    instr_ready_i = 1'b1;
    push(32'h00004505, 32'h0, 1'b1, 1'b0);
    push(32'h00510113, 32'h2, 1'b0, 1'b0);
    push(32'h0000ABCD, 32'h6, 1'b1, 1'b0);
    send_word(32'h01134505, 1'b0);
    checks++;
    if (instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL split_first: got valid %b, required 1", instr_valid_o);
    end
    tick();
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL split_wait: got valid %b, required 0", instr_valid_o);
    end
    send_word(32'hABCD0051, 1'b0);
    checks++;
    if (instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL split_complete: got valid %b, required 1", instr_valid_o);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL split_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int          k;
    logic        acc;
    words[0] = 32'h00A30113;
    words[1] = 32'h4509450D;
    words[2] = 32'h45114511;
    k        = 0;
    instr_ready_i = 1'b0;
    push(32'h00A30113, 32'h40, 1'b0, 1'b0);
    push(32'h0000450D, 32'h44, 1'b1, 1'b0);
    push(32'h00004509, 32'h46, 1'b1, 1'b0);
    push(32'h00004511, 32'h48, 1'b1, 1'b0);
    push(32'h00004511, 32'h4A, 1'b1, 1'b0);
    do_redirect(32'h40);
    fetch_valid_i = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      fetch_rdata_i = words[k];
      @(negedge clk);
      checks++;
      if (fetch_ready_o !== (k < 2)) begin
        errors++;
        $display("FAIL hold_ready: cycle %0d got %b, required %b", cyc, fetch_ready_o, k < 2);
      end
      if (k >= 1) begin
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o.insn !== 32'h00A30113 ||
            instr_o.pc !== 32'h40) begin
          errors++;
          $display("FAIL hold_stable: cycle %0d got valid %b insn %h pc %h, required 1 00a30113 00000040",
                   cyc, instr_valid_o, instr_o.insn, instr_o.pc);
        end
      end
      acc = fetch_ready_o;
      tick();
      if (acc) k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL hold_accepts: got %0d words, required 2", k);
    end
    instr_ready_i = 1'b1;
    send_word(words[2], 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_count3();
    instr_ready_i = 1'b0;
    push(32'h00001234, 32'h42, 1'b1, 1'b0);
    push(32'h0000450D, 32'h44, 1'b1, 1'b0);
    push(32'h00004509, 32'h46, 1'b1, 1'b0);
    do_redirect(32'h42);
    send_word(32'h1234FFFF, 1'b0);
    checks++;
    if (fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL count1_ready: got %b, required 1", fetch_ready_o);
    end
    send_word(32'h4509450D, 1'b0);
    checks++;
    if (fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL count3_ready: got %b, required 0", fetch_ready_o);
    end
    instr_ready_i = 1'b1;
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL count3_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_fetch_err();
    instr_ready_i = 1'b1;
    push(32'h0, 32'h80, 1'b0, 1'b1);
    push(32'h0, 32'h82, 1'b0, 1'b1);
    push(32'h00004509, 32'h84, 1'b1, 1'b0);
    push(32'h00004505, 32'h86, 1'b1, 1'b0);
    do_redirect(32'h80);
    send_word(32'hDEAD0113, 1'b1);
    send_word(32'h45054509, 1'b0);
    drain();
    tick();
    checks++;
    if (exp_q.size() != 0 || instr_o.pc !== 32'h88) begin
      errors++;
      $display("FAIL fetch_err_drain: got pending %0d pc %h, required 0 00000088",
               exp_q.size(), instr_o.pc);
    end
  endtask

  task automatic test_redirect_drop();
    instr_ready_i = 1'b0;
    do_redirect(32'h300);
    send_word(32'h45054505, 1'b0);
    tick();
    checks++;
    if (instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre: got valid %b, required 1", instr_valid_o);
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h310;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h45094509;
    instr_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: got %b, required 0", fetch_ready_o);
    end
    tick();
    redirect_i    = 1'b0;
    fetch_valid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o.pc !== 32'h310) begin
      errors++;
      $display("FAIL drop_after: got valid %b pc %h, required 0 00000310",
               instr_valid_o, instr_o.pc);
    end
    tick();
    tick();
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_word: got valid %b, required 0", instr_valid_o);
    end
    push(32'h0000450D, 32'h310, 1'b1, 1'b0);
    push(32'h00004511, 32'h312, 1'b1, 1'b0);
    send_word(32'h4511450D, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_redirect_32();
    test_skip_lo();
    test_reset_mid();
    test_split();
    test_back_to_back();
    test_count3();
    test_fetch_err();
    test_redirect_drop();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
